// File: rtl/seq_pkg.sv
// Shared encodings for the step sequencer: FSM states, opcodes, opcode classes
// and jump conditions.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_OPERAND = 3'd3,
      ST_EXEC    = 3'd4,
      ST_WRITE   = 3'd5,
      ST_HALT    = 3'd6,
      ST_FAULT   = 3'd7
   } state_t;

   localparam logic [7:0] OP_STORE = 8'h00;
   localparam logic [7:0] OP_MOVIR = 8'h02;
   localparam logic [7:0] OP_LOAD  = 8'h11;
   localparam logic [7:0] OP_LOADI = 8'h15;
   localparam logic [7:0] OP_ADD   = 8'h21;
   localparam logic [7:0] OP_ADDI  = 8'h25;
   localparam logic [7:0] OP_SUB   = 8'h31;
   localparam logic [7:0] OP_JZ    = 8'hF0;
   localparam logic [7:0] OP_JGZ   = 8'hF1;
   localparam logic [7:0] OP_JMP   = 8'hFE;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   typedef enum logic [2:0] {
      CLS_STORE,
      CLS_MEMOP,
      CLS_EXEC,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   typedef enum logic [1:0] {
      JC_NONE,
      JC_ALWAYS,
      JC_ZERO,
      JC_POS
   } jump_cond_t;

   // RON sign flags as presented on cmp
   localparam logic [1:0] CMP_ZERO = 2'b00;
   localparam logic [1:0] CMP_POS  = 2'b11;

   function automatic logic is_request(input state_t s);
      return (s == ST_FETCH) || (s == ST_OPERAND) || (s == ST_WRITE);
   endfunction

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode decoder: instruction class plus the per-instruction
// RON/IR write-enables and jump condition used in EXEC.
module op_classifier
   import seq_pkg::*;
(
   input  logic [7:0] i_opcode,
   output op_class_t  o_class,
   output logic       o_ron_load,
   output logic       o_ir_load,
   output jump_cond_t o_jump_cond
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      o_class     = CLS_ILLEGAL;
      o_ron_load  = 1'b0;
      o_ir_load   = 1'b0;
      o_jump_cond = JC_NONE;
      case (i_opcode)
         OP_STORE: o_class = CLS_STORE;
         OP_LOAD, OP_ADD, OP_SUB: begin
            o_class    = CLS_MEMOP;
            o_ron_load = 1'b1;
            o_ir_load  = 1'b1;
         end
         OP_LOADI, OP_ADDI: begin
            o_class    = CLS_EXEC;
            o_ron_load = 1'b1;
            o_ir_load  = 1'b1;
         end
         OP_MOVIR: begin
            o_class   = CLS_EXEC;
            o_ir_load = 1'b1;
         end
         // IR is rewritten (zeroed) by jumps as well
         OP_JZ: begin
            o_class     = CLS_EXEC;
            o_ir_load   = 1'b1;
            o_jump_cond = JC_ZERO;
         end
         OP_JGZ: begin
            o_class     = CLS_EXEC;
            o_ir_load   = 1'b1;
            o_jump_cond = JC_POS;
         end
         OP_JMP: begin
            o_class     = CLS_EXEC;
            o_ir_load   = 1'b1;
            o_jump_cond = JC_ALWAYS;
         end
         OP_HALT: o_class = CLS_HALT;
         default: o_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/step_sequencer.sv
// Multi-cycle control FSM for the accumulator datapath over one shared,
// req/ack-handshaked memory port, with a wait timeout and retired counter.
module step_sequencer
   import seq_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [7:0]       opcode,
   input  logic [1:0]       cmp,
   input  logic             memAck,
   output logic             memReq,
   output logic             memSel,
   output logic             memWe,
   output logic             cmdLatch,
   output logic             opLatch,
   output logic             ronLoad,
   output logic             irLoad,
   output logic             cpLoad,
   output logic             cpJump,
   output logic             halted,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   state_t           r_state;
   logic [7:0]       r_wait;
   logic [CNT_W-1:0] r_retired;

   op_class_t  w_class;
   jump_cond_t w_jump_cond;
   logic       w_ron_load;
   logic       w_ir_load;
   logic       w_req;
   logic       w_timeout;
   logic       w_done;
   logic       w_jump_taken;

   op_classifier u_classifier (
      .i_opcode    (opcode),
      .o_class     (w_class),
      .o_ron_load  (w_ron_load),
      .o_ir_load   (w_ir_load),
      .o_jump_cond (w_jump_cond)
   );

   assign w_req     = is_request(r_state);
   assign w_timeout = w_req && !memAck && (r_wait == WAIT_LAST);
   // The cpLoad cycle is the instruction's completion point
   assign w_done    = (r_state == ST_EXEC) || ((r_state == ST_WRITE) && memAck);

   always_comb begin
      case (w_jump_cond)
         JC_ALWAYS: w_jump_taken = 1'b1;
         JC_ZERO:   w_jump_taken = (cmp == CMP_ZERO);
         JC_POS:    w_jump_taken = (cmp == CMP_POS);
         default:   w_jump_taken = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_wait    <= '0;
         r_retired <= '0;
      end else begin
         if (w_done) r_retired <= r_retired + 1'b1;
         // Counts unacknowledged request cycles; any other cycle clears it
         r_wait <= (w_req && !memAck) ? r_wait + 8'd1 : 8'd0;

         case (r_state)
            ST_IDLE:    if (run) r_state <= ST_FETCH;
            ST_FETCH: begin
               if (memAck)         r_state <= ST_DECODE;
               else if (w_timeout) r_state <= ST_FAULT;
            end
            ST_DECODE: begin
               case (w_class)
                  CLS_STORE: r_state <= ST_WRITE;
                  CLS_MEMOP: r_state <= ST_OPERAND;
                  CLS_EXEC:  r_state <= ST_EXEC;
                  CLS_HALT:  r_state <= ST_HALT;
                  default:   r_state <= ST_FAULT;
               endcase
            end
            ST_OPERAND: begin
               if (memAck)         r_state <= ST_EXEC;
               else if (w_timeout) r_state <= ST_FAULT;
            end
            ST_EXEC:    r_state <= run ? ST_FETCH : ST_IDLE;
            ST_WRITE: begin
               if (memAck)         r_state <= run ? ST_FETCH : ST_IDLE;
               else if (w_timeout) r_state <= ST_FAULT;
            end
            default:    r_state <= r_state;
         endcase
      end
   end

   always_comb begin
      memReq   = w_req;
      memSel   = (r_state == ST_OPERAND) || (r_state == ST_WRITE);
      memWe    = (r_state == ST_WRITE);
      cmdLatch = (r_state == ST_FETCH) && memAck;
      opLatch  = (r_state == ST_OPERAND) && memAck;
      ronLoad  = (r_state == ST_EXEC) && w_ron_load;
      irLoad   = (r_state == ST_EXEC) && w_ir_load;
      cpLoad   = w_done;
      cpJump   = (r_state == ST_EXEC) && w_jump_taken;
      halted   = (r_state == ST_HALT);
      fault    = (r_state == ST_FAULT);
      state    = r_state;
      retired  = r_retired;
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: a per-instruction planner builds the expected
// cycle trace from the instruction rules and randomized memory waits.
module tb_step_sequencer;
   import seq_pkg::*;

   localparam int WL = 15;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset, run, memAck;
   logic [7:0]    opcode;
   logic [1:0]    cmp;
   logic          memReq, memSel, memWe, cmdLatch, opLatch, ronLoad, irLoad;
   logic          cpLoad, cpJump, halted, fault;
   logic [2:0]    state;
   logic [CW-1:0] retired;

   step_sequencer #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .run(run), .opcode(opcode), .cmp(cmp),
      .memAck(memAck), .memReq(memReq), .memSel(memSel), .memWe(memWe),
      .cmdLatch(cmdLatch), .opLatch(opLatch), .ronLoad(ronLoad), .irLoad(irLoad),
      .cpLoad(cpLoad), .cpJump(cpJump), .halted(halted), .fault(fault),
      .state(state), .retired(retired)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One planned clock cycle: inputs to drive and outputs required
   typedef struct {
      logic       run;
      logic [7:0] opc;
      logic [1:0] cmp;
      logic       ack;
      logic       req, sel, we, cmdl, opl, ron, irl, cpl, cpj, hlt, flt;
      state_t     st;
      int unsigned ret;
   } cyc_t;

   cyc_t        plan[$];
   int unsigned m_ret = 0;
   int          cyc_no = 0;

   function automatic logic [13:0] exp_vec(input cyc_t c);
      return {c.req, c.sel, c.we, c.cmdl, c.opl, c.ron, c.irl, c.cpl, c.cpj,
              c.hlt, c.flt, 3'(c.st)};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {memReq, memSel, memWe, cmdLatch, opLatch, ronLoad, irLoad, cpLoad,
              cpJump, halted, fault, state};
   endfunction

   // Unconstrained inputs are random so the DUT must ignore them
   function automatic cyc_t blank(input state_t s);
      cyc_t c;
      c.run = 1'($urandom_range(0, 1));
      c.opc = 8'($urandom);
      c.cmp = 2'($urandom_range(0, 3));
      c.ack = 1'($urandom_range(0, 1));
      {c.req, c.sel, c.we, c.cmdl, c.opl, c.ron, c.irl, c.cpl, c.cpj, c.hlt, c.flt} = '0;
      c.st  = s;
      c.ret = m_ret;
      return c;
   endfunction

   task automatic add_idle(input logic run_v);
      cyc_t c = blank(ST_IDLE);
      c.run = run_v;
      plan.push_back(c);
   endtask

   task automatic add_stuck(input state_t s, input int n);
      for (int k = 0; k < n; k++) begin
         cyc_t c = blank(s);
         c.hlt = (s == ST_HALT);
         c.flt = (s == ST_FAULT);
         plan.push_back(c);
      end
   endtask

   // d unacknowledged request cycles; WL of them exhaust the wait budget
   task automatic add_waits(input state_t s, input logic sel, input logic we,
                            input logic [7:0] opc, input int d, output bit to);
      for (int k = 0; k < d && k < WL; k++) begin
         cyc_t c = blank(s);
         c.req = 1'b1; c.sel = sel; c.we = we; c.ack = 1'b0;
         if (s != ST_FETCH) c.opc = opc;
         plan.push_back(c);
      end
      to = (d >= WL);
   endtask

   task automatic finish_instr(input cyc_t c, input logic run_after);
      c.cpl = 1'b1;
      c.run = run_after;
      plan.push_back(c);
      m_ret = (m_ret + 1) % (1 << CW);
   endtask

   task automatic add_exec(input logic [7:0] opc, input logic [1:0] cv, input logic run_after);
      cyc_t c = blank(ST_EXEC);
      c.opc = opc;
      c.cmp = cv;
      c.irl = 1'b1;
      c.ron = opc inside {8'h11, 8'h15, 8'h21, 8'h25, 8'h31};
      c.cpj = (opc == 8'hFE) || (opc == 8'hF0 && cv == 2'b00) || (opc == 8'hF1 && cv == 2'b11);
      finish_instr(c, run_after);
   endtask

   task automatic add_instr(input logic [7:0] opc, input logic [1:0] cv,
                            input int d0, input int d1, input logic run_after);
      cyc_t c;
      bit   to;
      add_waits(ST_FETCH, 1'b0, 1'b0, opc, d0, to);
      if (to) begin add_stuck(ST_FAULT, 6); return; end
      c = blank(ST_FETCH);
      c.req = 1'b1; c.ack = 1'b1; c.cmdl = 1'b1;
      plan.push_back(c);
      c = blank(ST_DECODE);
      c.opc = opc;
      plan.push_back(c);
      case (opc)
         8'h00: begin
            add_waits(ST_WRITE, 1'b1, 1'b1, opc, d1, to);
            if (to) begin add_stuck(ST_FAULT, 6); return; end
            c = blank(ST_WRITE);
            c.opc = opc; c.req = 1'b1; c.sel = 1'b1; c.we = 1'b1; c.ack = 1'b1;
            finish_instr(c, run_after);
         end
         8'h11, 8'h21, 8'h31: begin
            add_waits(ST_OPERAND, 1'b1, 1'b0, opc, d1, to);
            if (to) begin add_stuck(ST_FAULT, 6); return; end
            c = blank(ST_OPERAND);
            c.opc = opc; c.req = 1'b1; c.sel = 1'b1; c.ack = 1'b1; c.opl = 1'b1;
            plan.push_back(c);
            add_exec(opc, cv, run_after);
         end
         8'h15, 8'h25, 8'h02, 8'hF0, 8'hF1, 8'hFE: add_exec(opc, cv, run_after);
         8'hFF:   add_stuck(ST_HALT, 8);
         default: add_stuck(ST_FAULT, 6);
      endcase
   endtask

   // Drive each planned cycle 1 ns after the edge, compare 2 ns later
   task automatic run_plan(input bit stop_in_operand);
      cyc_t c;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(posedge clock);
         #1;
         run = c.run; opcode = c.opc; cmp = c.cmp; memAck = c.ack;
         #2;
         check($sformatf("cyc%0d_outputs", cyc_no), 32'(dut_vec()), 32'(exp_vec(c)));
         check($sformatf("cyc%0d_retired", cyc_no), 32'(retired), c.ret);
         cyc_no++;
         if (stop_in_operand && c.st == ST_OPERAND) plan.delete();
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1; run = 1'b0; memAck = 1'b0; opcode = 8'h00; cmp = 2'b00;
      #1;
      check({tag, "_outputs"}, 32'(dut_vec()), 32'({11'b0, 3'(ST_IDLE)}));
      check({tag, "_retired"}, 32'(retired), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      m_ret = 0;
   endtask

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: got no finish, expected finish before 1000000 ns");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] legal [10] = '{8'h00, 8'h02, 8'h11, 8'h15, 8'h21, 8'h25,
                                 8'h31, 8'hF0, 8'hF1, 8'hFE};
      int sz;

      do_reset("por");

      // Directed sequence with literal latencies pinning the planner
      add_idle(1'b0); add_idle(1'b0); add_idle(1'b1);
      sz = plan.size(); add_instr(8'h11, 2'b00, 0, 0, 1'b1);
      check("lat_load_zero_wait", 32'(plan.size() - sz), 32'd4);
      add_instr(8'hF0, 2'b00, 0, 0, 1'b1);
      add_instr(8'hF0, 2'b11, 0, 0, 1'b1);
      sz = plan.size(); add_instr(8'h15, 2'b00, 0, 0, 1'b1);
      check("lat_imm_zero_wait", 32'(plan.size() - sz), 32'd3);
      sz = plan.size(); add_instr(8'h00, 2'b00, 0, 0, 1'b1);
      check("lat_store_zero_wait", 32'(plan.size() - sz), 32'd3);
      sz = plan.size(); add_instr(8'h00, 2'b00, 0, 3, 1'b0);
      check("lat_store_wait3", 32'(plan.size() - sz), 32'd6);
      add_idle(1'b0);
      run_plan(1'b0);
      check("retired_directed", 32'(retired), 32'd6);

      // Randomized legal instructions, memory waits and run gaps
      add_idle(1'b1);
      for (int i = 0; i < 150; i++) begin
         logic [7:0] opc = legal[$urandom_range(0, 9)];
         int d0 = ($urandom_range(0, 9) == 0) ? $urandom_range(4, WL - 1) : $urandom_range(0, 2);
         int d1 = ($urandom_range(0, 9) == 0) ? $urandom_range(4, WL - 1) : $urandom_range(0, 2);
         logic ra = ($urandom_range(0, 4) != 0);
         add_instr(opc, 2'($urandom_range(0, 3)), d0, d1, ra);
         if (!ra) begin
            repeat ($urandom_range(0, 2)) add_idle(1'b0);
            add_idle(1'b1);
         end
      end
      run_plan(1'b0);
      do_reset("rst_after_random");

      // Illegal opcode
      add_idle(1'b1);
      add_instr(8'h7A, 2'b00, 1, 0, 1'b1);
      run_plan(1'b0);
      check("illegal_fault", 32'(fault), 32'd1);
      do_reset("rst_after_illegal");

      // Halt after one retired instruction
      add_idle(1'b1);
      add_instr(8'h11, 2'b00, 0, 1, 1'b1);
      add_instr(8'hFF, 2'b00, 0, 0, 1'b1);
      run_plan(1'b0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_retired", 32'(retired), 32'd1);
      do_reset("rst_after_halt");

      // Fetch timeout: WL request cycles then six observed FAULT cycles
      add_idle(1'b1);
      sz = plan.size(); add_instr(8'h15, 2'b00, WL, 0, 1'b1);
      check("timeout_plan_len", 32'(plan.size() - sz), 32'd21);
      run_plan(1'b0);
      check("timeout_fault", 32'(fault), 32'd1);
      check("timeout_req_low", 32'(memReq), 32'd0);
      do_reset("rst_after_timeout");

      // Counter at all-ones, then reset in the middle of OPERAND
      add_idle(1'b1);
      for (int i = 0; i < (1 << CW) - 1; i++) add_instr(8'h15, 2'b00, 0, 0, 1'b1);
      add_instr(8'h11, 2'b00, 0, 5, 1'b1);
      run_plan(1'b1);
      check("pre_reset_retired", 32'(retired), 32'hFF);
      check("pre_reset_operand", 32'(state), 32'(ST_OPERAND));
      do_reset("rst_mid_operand");

      // Full wrap of the retired counter
      add_idle(1'b1);
      for (int i = 0; i < (1 << CW); i++) add_instr(8'hFE, 2'b00, 0, 0, (i < (1 << CW) - 1));
      add_idle(1'b0);
      run_plan(1'b0);
      check("wrap_retired", 32'(retired), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
